cv32e41p_sleep_ctrl: RTL and testbench
======================================

# cv32e41p_sleep_ctrl

Sequences the core clock gate enable in an ungated clock domain. Detects core inactivity, performs a sleep request/acknowledge handshake with the core, and gates the clock once acknowledged. Re-enables the clock on any of several wake sources and records which source caused the wake-up. Sits between the core's idle/status signals and the `en_i` input of `cv32e41p_clock_gate`.

## Interface
- `IDLE_CYCLES`, default 8: hysteresis length in quiet cycles before sleep is requested; must be ≥1.
- `WAKE_CYCLES`, default 2: settle cycles after clock re-enable before `sleeping_o` drops; must be ≥1.
- `NUM_WAKE`, default 4: number of wake sources; must be ≥1.

- `clk_i`  in  1  free-running, ungated clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `scan_cg_en_i`  in  1  test mode; forces `clock_en_o` high and has no effect on the FSM.
- `core_busy_i`  in  1  core activity indication; high means not idle.
- `wake_i`  in  NUM_WAKE  wake/activity requests; level-sensitive; generated in the ungated domain.
- `sleep_ack_i`  in  1  core confirms it is quiesced.
- `sleep_req_o`  out  1  request to the core to quiesce.
- `clock_en_o`  out  1  drives the clock gate `en_i`.
- `sleeping_o`  out  1  high from gating until wake settle completes.
- `wake_src_o`  out  NUM_WAKE  one-hot cause of the last wake-up; held until the next wake-up.

## Operation
- Definition: quiet = `!core_busy_i && !(|wake_i)`.
- FSM states: RUN, IDLE_CNT, REQ, SLEEP, WAKE. Reset state is RUN.
- Single down-counter, width `$clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1)`, shared by IDLE_CNT and WAKE. Reset value is 0.
- RUN
  - If quiet: go to IDLE_CNT and load counter = IDLE_CYCLES.
  - Otherwise stay in RUN.
- IDLE_CNT
  - If not quiet: go to RUN and clear the counter.
  - Else if counter == 1: go to REQ.
  - Else: decrement the counter.
- REQ (`sleep_req_o`=1)
  - If `|wake_i`: go to RUN (abort). Wake wins over a simultaneous `sleep_ack_i`.
  - Else if `sleep_ack_i`: go to SLEEP.
  - `core_busy_i` is ignored in REQ; the core owns quiescing once asked.
- SLEEP
  - If `|wake_i`: go to WAKE, load counter = WAKE_CYCLES, and latch `wake_src_o` = lowest-index set bit of `wake_i` (one-hot).
- WAKE
  - Decrement the counter; at counter == 1 go to RUN.
  - `wake_i` and `core_busy_i` are ignored in WAKE.
- Outputs, decoded from the registered state:
  - `sleep_req_o` = (state==REQ).
  - `sleeping_o` = (state==SLEEP || state==WAKE).
  - `clock_en_o` = (state!=SLEEP) | `scan_cg_en_i`.
- `rst_i` asserted in any state, including SLEEP: next state is RUN, counter 0, `wake_src_o` 0. Therefore `clock_en_o` is 1 one cycle after the reset edge.
- Reset values: `sleep_req_o`=0, `clock_en_o`=1, `sleeping_o`=0, `wake_src_o`=0.

## Timing
- All state changes occur on the rising edge of `clk_i`. Outputs change only after an edge, plus `scan_cg_en_i` combinationally.
- Sleep entry (hysteresis enabled): quiet sampled at N+1 consecutive edges (N=IDLE_CYCLES) → `sleep_req_o` high after edge N+1.
- Ack sampled at edge a → `clock_en_o` low and `sleeping_o` high after edge a.
- Wake latency: `wake_i` sampled at edge e in SLEEP → `clock_en_o` high after edge e.
  - The gate latch passes the enable in the following clock-low phase, so the first gated rising edge is e+1.
- `sleeping_o` falls after edge e+WAKE_CYCLES.
- A one-cycle wake pulse in SLEEP is sufficient; a wake pulse in WAKE is dropped.

## Configuration
- `CV32E41P_SLEEP_HYST_EN` defined: IDLE_CNT state and hysteresis behave as above.
- Not defined:
  - IDLE_CNT is not built.
  - RUN goes directly to REQ on a single quiet edge.
  - `IDLE_CYCLES` is ignored; counter width is `$clog2(WAKE_CYCLES+1)`.

## Test plan
- Hysteresis: macro on, IDLE_CYCLES=8, hold quiet → `sleep_req_o` rises after edge 9; `core_busy_i` pulse at edge 5 → back to RUN, full 9-edge count restarts.
- Full cycle: ack one cycle after req → `clock_en_o`=0, `sleeping_o`=1. Then `wake_i`=4'b0110 for one cycle → `clock_en_o`=1 next cycle, `wake_src_o`=4'b0010, `sleeping_o` falls 2 cycles after the wake edge.
- Race: `wake_i`=4'b1000 and `sleep_ack_i` high on the same edge in REQ → RUN, `clock_en_o` stays 1, `wake_src_o` unchanged.
- Reset in SLEEP: assert `rst_i` one cycle → `clock_en_o`=1, `sleeping_o`=0, `wake_src_o`=0 after the edge; FSM in RUN.
- Scan: `scan_cg_en_i`=1 while in SLEEP → `clock_en_o`=1 combinationally, state still SLEEP, `sleeping_o`=1.
- Macro off: one quiet edge → `sleep_req_o` high after that edge.

Source files
------------

// File: rtl/cv32e41p_sleep_ctrl.sv
// Core sleep sequencer: idle detection, sleep request/ack handshake, clock gate enable and wake-cause capture.
// Optional idle hysteresis (IDLE_CNT state) is built when CV32E41P_SLEEP_HYST_EN is defined.
module cv32e41p_sleep_ctrl #(
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned NUM_WAKE    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                scan_cg_en_i,
  input  logic                core_busy_i,
  input  logic [NUM_WAKE-1:0] wake_i,
  input  logic                sleep_ack_i,
  output logic                sleep_req_o,
  output logic                clock_en_o,
  output logic                sleeping_o,
  output logic [NUM_WAKE-1:0] wake_src_o
);

`ifdef CV32E41P_SLEEP_HYST_EN
  localparam int unsigned CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
`else
  localparam int unsigned CNT_MAX = WAKE_CYCLES;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  generate
    if (IDLE_CYCLES == 0 || WAKE_CYCLES == 0 || NUM_WAKE == 0) begin : g_bad_param
      $error("cv32e41p_sleep_ctrl: IDLE_CYCLES, WAKE_CYCLES and NUM_WAKE must all be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    RUN      = 3'd0,
`ifdef CV32E41P_SLEEP_HYST_EN
    IDLE_CNT = 3'd1,
`endif
    REQ      = 3'd2,
    SLEEP    = 3'd3,
    WAKE     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_WAKE-1:0] src_q, src_d;
  logic [NUM_WAKE-1:0] wake_lsb;
  logic                wake_any;
  logic                quiet;
  logic                req_q;
  logic                gate_off_q;
  logic                sleeping_q;

  assign wake_any = |wake_i;
  assign quiet    = !core_busy_i && !wake_any;

  // One-hot of the lowest-index active wake source.
  always_comb begin
    logic found;
    wake_lsb = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_WAKE; i++) begin
      if (wake_i[i] && !found) begin
        wake_lsb[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Next-state, shared counter and wake-cause logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    case (state_q)
      RUN: begin
        if (quiet) begin
`ifdef CV32E41P_SLEEP_HYST_EN
          state_d = IDLE_CNT;
          cnt_d   = CNT_W'(IDLE_CYCLES);
`else
          state_d = REQ;
`endif
        end
      end
`ifdef CV32E41P_SLEEP_HYST_EN
      IDLE_CNT: begin
        if (!quiet) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      REQ: begin
        // A wake request aborts the handshake even if the ack arrives on the same edge.
        if (wake_any) begin
          state_d = RUN;
        end else if (sleep_ack_i) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (wake_any) begin
          state_d = WAKE;
          cnt_d   = CNT_W'(WAKE_CYCLES);
          src_d   = wake_lsb;
        end
      end
      WAKE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State register plus flopped output decodes so the gate enable never glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      src_q      <= '0;
      req_q      <= 1'b0;
      gate_off_q <= 1'b0;
      sleeping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      req_q      <= (state_d == REQ);
      gate_off_q <= (state_d == SLEEP);
      sleeping_q <= (state_d == SLEEP) || (state_d == WAKE);
    end
  end

  assign sleep_req_o = req_q;
  assign sleeping_o  = sleeping_q;
  assign wake_src_o  = src_q;
  // Scan mode bypasses the gate without disturbing the sequencer.
  assign clock_en_o  = !gate_off_q || scan_cg_en_i;

endmodule

// File: tb/tb_cv32e41p_sleep_ctrl.sv
// Table-driven bench for cv32e41p_sleep_ctrl; follows CV32E41P_SLEEP_HYST_EN if defined.
module tb_cv32e41p_sleep_ctrl;

  localparam int unsigned NW = 4;

  logic          clk;
  logic          rst;
  logic          scan;
  logic          busy;
  logic [NW-1:0] wake;
  logic          ack;
  logic          req;
  logic          clk_en;
  logic          sleeping;
  logic [NW-1:0] src;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic          scan;
    logic          busy;
    logic [NW-1:0] wake;
    logic          ack;
    logic          req;
    logic          en;
    logic          slp;
    logic [NW-1:0] src;
  } vec_t;

  vec_t vecs[$];

  cv32e41p_sleep_ctrl #(
    .IDLE_CYCLES(8),
    .WAKE_CYCLES(2),
    .NUM_WAKE   (NW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .scan_cg_en_i(scan),
    .core_busy_i (busy),
    .wake_i      (wake),
    .sleep_ack_i (ack),
    .sleep_req_o (req),
    .clock_en_o  (clk_en),
    .sleeping_o  (sleeping),
    .wake_src_o  (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic sc, input logic b, input logic [NW-1:0] w,
                              input logic a, input logic e_req, input logic e_en, input logic e_slp,
                              input logic [NW-1:0] e_src);
    vec_t v;
    v = '{r, sc, b, w, a, e_req, e_en, e_slp, e_src};
    vecs.push_back(v);
  endfunction

  // Quiet edges from RUN until sleep_req_o rises.
  function automatic void enter_req(input logic [NW-1:0] s);
`ifdef CV32E41P_SLEEP_HYST_EN
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, s);
`endif
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, s);
  endfunction

  task automatic check(input string name, input int row, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst  = vecs[i].rst;
      scan = vecs[i].scan;
      busy = vecs[i].busy;
      wake = vecs[i].wake;
      ack  = vecs[i].ack;
      @(posedge clk);
      #1;
      check("sleep_req", i, NW'(req), NW'(vecs[i].req));
      check("clock_en", i, NW'(clk_en), NW'(vecs[i].en));
      check("sleeping", i, NW'(sleeping), NW'(vecs[i].slp));
      check("wake_src", i, src, vecs[i].src);
    end
  endtask

  initial begin
    rst  = 1'b1;
    scan = 1'b0;
    busy = 1'b1;
    wake = '0;
    ack  = 1'b0;

    add(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    enter_req(4'b0000);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010);
    enter_req(4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010);
    enter_req(4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010);
    add(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    enter_req(4'b0000);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001);
    add(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
`ifdef CV32E41P_SLEEP_HYST_EN
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
`endif
    enter_req(4'b0001);
    add(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    run_table();

    // Scan override between edges while asleep.
    vecs.delete();
    enter_req(4'b0000);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    run_table();
    @(negedge clk);
    ack  = 1'b0;
    scan = 1'b1;
    #1;
    check("scan_en_comb", -1, NW'(clk_en), NW'(1'b1));
    check("scan_sleeping", -1, NW'(sleeping), NW'(1'b1));
    scan = 1'b0;
    #1;
    check("scan_release", -1, NW'(clk_en), NW'(1'b0));

    vecs.delete();
    add(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000);
    add(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000);
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
